// File: rtl/simon_stream_scheduler_if.sv
// Ingress FIFO, egress FIFO and round-engine signals of the Simon stream scheduler.
// master = scheduler side, slave = FIFOs and engine.
interface simon_stream_scheduler_if #(
    parameter int DATA_WIDTH = 128
);
    // Handshake: a word moves on a rising clk edge where vld && rdy; the source
    // holds vld and data stable until then.
    logic [DATA_WIDTH-1:0] ingress_fifo_dout;
    logic                  ingress_fifo_vld;
    logic                  ingress_fifo_rdy;
    logic [DATA_WIDTH-1:0] egress_fifo_din;
    logic                  egress_fifo_vld;
    logic                  egress_fifo_rdy;
    logic [DATA_WIDTH-1:0] core_key;
    logic                  core_key_load;
    logic [DATA_WIDTH-1:0] core_din;
    logic                  core_mode;
    logic                  core_start;
    logic                  core_busy;
    logic                  core_done;
    logic [DATA_WIDTH-1:0] core_dout;

    modport master (
        input  ingress_fifo_dout, ingress_fifo_vld, egress_fifo_rdy,
        input  core_busy, core_done, core_dout,
        output ingress_fifo_rdy, egress_fifo_din, egress_fifo_vld,
        output core_key, core_key_load, core_din, core_mode, core_start
    );

    modport slave (
        output ingress_fifo_dout, ingress_fifo_vld, egress_fifo_rdy,
        output core_busy, core_done, core_dout,
        input  ingress_fifo_rdy, egress_fifo_din, egress_fifo_vld,
        input  core_key, core_key_load, core_din, core_mode, core_start
    );
endinterface

// File: rtl/simon_stream_scheduler.sv
// Command sequencer: pops headers/keys/blocks from the ingress FIFO, drives the
// Simon round engine one block at a time and pushes each result to the egress FIFO.
module simon_stream_scheduler #(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    simon_stream_scheduler_if.master bus,
    output logic                     key_loaded,
    output logic                     err_opcode,
    output logic                     err_nokey,
    output logic [31:0]              blocks_done,
    output logic [2:0]               dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEY   = 3'd1,
        S_FEED  = 3'd2,
        S_WAIT  = 3'd3,
        S_PUSH  = 3'd4,
        S_FLUSH = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] key_q, key_d;
    logic                  key_load_q, key_load_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  mode_q, mode_d;
    logic                  start_q, start_d;
    logic [DATA_WIDTH-1:0] eg_din_q, eg_din_d;
    logic                  eg_vld_q, eg_vld_d;
    logic                  key_loaded_q, key_loaded_d;
    logic                  err_opcode_q, err_opcode_d;
    logic                  err_nokey_q, err_nokey_d;
    logic [31:0]           blocks_q, blocks_d;

    logic                  in_rdy;
    logic                  pop;
    logic [7:0]            opcode;
    logic [CNT_WIDTH-1:0]  hdr_n;

    assign opcode = bus.ingress_fifo_dout[DATA_WIDTH-1 -: 8];
    assign hdr_n  = bus.ingress_fifo_dout[CNT_WIDTH-1:0];

    // Only non-registered output; forced low while reset is held.
    always_comb begin
        in_rdy = 1'b0;
        case (state_q)
            S_IDLE, S_KEY, S_FLUSH: in_rdy = 1'b1;
            S_FEED:                 in_rdy = ~bus.core_busy;
            default:                in_rdy = 1'b0;
        endcase
        if (!rst) in_rdy = 1'b0;
    end

    assign pop = bus.ingress_fifo_vld & in_rdy;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        key_load_d   = 1'b0;
        din_d        = din_q;
        mode_d       = mode_q;
        start_d      = 1'b0;
        eg_din_d     = eg_din_q;
        eg_vld_d     = eg_vld_q;
        key_loaded_d = key_loaded_q;
        err_opcode_d = err_opcode_q;
        err_nokey_d  = err_nokey_q;
        blocks_d     = blocks_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    case (opcode)
                        8'h01: state_d = S_KEY;
                        8'h02, 8'h03: begin
                            // N == 0 is a no-op: stay in IDLE
                            if (hdr_n != '0) begin
                                cnt_d = hdr_n;
                                if (!key_loaded_q) begin
                                    err_nokey_d = 1'b1;
                                    state_d     = S_FLUSH;
                                end else begin
                                    mode_d  = opcode[0];
                                    state_d = S_FEED;
                                end
                            end
                        end
                        default: err_opcode_d = 1'b1;
                    endcase
                end
            end
            S_KEY: begin
                if (pop) begin
                    key_d        = bus.ingress_fifo_dout;
                    key_load_d   = 1'b1;
                    key_loaded_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_FEED: begin
                if (pop) begin
                    din_d   = bus.ingress_fifo_dout;
                    start_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.core_done) begin
                    eg_din_d = bus.core_dout;
                    eg_vld_d = 1'b1;
                    state_d  = S_PUSH;
                end
            end
            S_PUSH: begin
                if (bus.egress_fifo_rdy) begin
                    eg_vld_d = 1'b0;
                    blocks_d = blocks_q + 32'd1;
                    cnt_d    = cnt_q - CNT_WIDTH'(1);
                    state_d  = (cnt_q == CNT_WIDTH'(1)) ? S_IDLE : S_FEED;
                end
            end
            S_FLUSH: begin
                if (pop) begin
                    cnt_d   = cnt_q - CNT_WIDTH'(1);
                    state_d = (cnt_q == CNT_WIDTH'(1)) ? S_IDLE : S_FLUSH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            key_q        <= '0;
            key_load_q   <= 1'b0;
            din_q        <= '0;
            mode_q       <= 1'b0;
            start_q      <= 1'b0;
            eg_din_q     <= '0;
            eg_vld_q     <= 1'b0;
            key_loaded_q <= 1'b0;
            err_opcode_q <= 1'b0;
            err_nokey_q  <= 1'b0;
            blocks_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            key_load_q   <= key_load_d;
            din_q        <= din_d;
            mode_q       <= mode_d;
            start_q      <= start_d;
            eg_din_q     <= eg_din_d;
            eg_vld_q     <= eg_vld_d;
            key_loaded_q <= key_loaded_d;
            err_opcode_q <= err_opcode_d;
            err_nokey_q  <= err_nokey_d;
            blocks_q     <= blocks_d;
        end
    end

    assign bus.ingress_fifo_rdy = in_rdy;
    assign bus.egress_fifo_din  = eg_din_q;
    assign bus.egress_fifo_vld  = eg_vld_q;
    assign bus.core_key         = key_q;
    assign bus.core_key_load    = key_load_q;
    assign bus.core_din         = din_q;
    assign bus.core_mode        = mode_q;
    assign bus.core_start       = start_q;
    assign key_loaded           = key_loaded_q;
    assign err_opcode           = err_opcode_q;
    assign err_nokey            = err_nokey_q;
    assign blocks_done          = blocks_q;
    assign dbg_state            = state_q;
endmodule

// File: tb/tb_simon_stream_scheduler.sv
// Directed + randomized bench for simon_stream_scheduler with a command-level
// reference model, an engine model and an egress scoreboard.
module tb_simon_stream_scheduler;
  localparam int DW = 128;
  localparam int CW = 16;
  localparam logic [2:0] DBG_IDLE = 3'd0;
  localparam logic [2:0] DBG_WAIT = 3'd3;
  localparam logic [127:0] K0 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] P0 = 128'h63736564207372656c6c657661727420;
  localparam logic [127:0] C0 = 128'h49681b1e1e54fe3f65aa832af84e0bbc;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  simon_stream_scheduler_if #(.DATA_WIDTH(DW)) bus ();
  logic        key_loaded, err_opcode, err_nokey;
  logic [31:0] blocks_done;
  logic [2:0]  dbg_state;

  simon_stream_scheduler #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .key_loaded  (key_loaded),
    .err_opcode  (err_opcode),
    .err_nokey   (err_nokey),
    .blocks_done (blocks_done),
    .dbg_state   (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] in_q[$];
  logic [127:0] exp_q[$];
  bit           in_accepted = 1'b0;
  int           pop_cnt = 0, push_cnt = 0, start_cnt = 0, key_load_cnt = 0;
  bit           eng_hold = 1'b0;
  logic [127:0] eng_key = '0;
  int           in_gap_pct = 0;
  int           eg_mode = 0;
  logic [127:0] eg_prev_din = '0;
  bit           eg_prev_stall = 1'b0;

  // reference model state
  logic [127:0] m_key;
  bit           m_key_loaded, m_err_op, m_err_nokey;
  int           m_blocks, m_starts, m_words, m_key_loads;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stand-in for the round engine: the published test vector, else a keyed scramble.
  function automatic logic [127:0] engine_fn(input logic [127:0] k, input logic [127:0] d, input bit m);
    logic [127:0] r;
    if (k == K0 && d == P0 && !m) return C0;
    r = d ^ {k[126:0], k[127]};
    r = {r[114:0], r[127:115]};
    if (m) r = ~r;
    return r;
  endfunction

  // driver: queue a command and update the reference model
  task automatic send_cmd(input logic [7:0] op, input int n, input logic [127:0] w0, input bit fixed0);
    logic [127:0] hdr, w;
    hdr = rand128();
    hdr[127:120] = op;
    hdr[15:0] = n[15:0];
    in_q.push_back(hdr);
    m_words++;
    if (op == 8'h01) begin
      w = fixed0 ? w0 : rand128();
      in_q.push_back(w);
      m_words++;
      m_key = w;
      m_key_loaded = 1'b1;
      m_key_loads++;
    end else if (op == 8'h02 || op == 8'h03) begin
      for (int i = 0; i < n; i++) begin
        w = (fixed0 && i == 0) ? w0 : rand128();
        in_q.push_back(w);
        m_words++;
        if (m_key_loaded) begin
          exp_q.push_back(engine_fn(m_key, w, op == 8'h03));
          m_blocks++;
          m_starts++;
        end
      end
      if (n != 0 && !m_key_loaded) m_err_nokey = 1'b1;
    end else begin
      m_err_op = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"}, 128'(bus.ingress_fifo_rdy), 128'(rst));
    check({tag, "_egdin"}, bus.egress_fifo_din, '0);
    check({tag, "_key"}, bus.core_key, '0);
    check({tag, "_cdin"}, bus.core_din, '0);
    check({tag, "_flags"}, 128'({bus.egress_fifo_vld, bus.core_key_load, bus.core_mode, bus.core_start,
                                 key_loaded, err_opcode, err_nokey}), '0);
    check({tag, "_blocks"}, 128'(blocks_done), '0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_q.delete();
    exp_q.delete();
    in_accepted = 1'b0;
    eg_prev_stall = 1'b0;
    bus.ingress_fifo_vld = 1'b0;
    m_key = '0; m_key_loaded = 0; m_err_op = 0; m_err_nokey = 0;
    m_blocks = 0; m_starts = 0; m_words = 0; m_key_loads = 0;
    pop_cnt = 0; push_cnt = 0; start_cnt = 0; key_load_cnt = 0;
    #1;
    check_reset_outputs("in_reset");
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");
    check("after_reset_state", 128'(dbg_state), 128'(DBG_IDLE));
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (c < budget && !(in_q.size() == 0 && exp_q.size() == 0 && dbg_state == DBG_IDLE &&
                           !bus.egress_fifo_vld && !bus.core_busy)) begin
      @(negedge clk);
      c++;
    end
    check("drain_in_budget", 128'(c < budget), 128'(1));
  endtask

  task automatic check_model(input string tag);
    check({tag, "_blocks"}, 128'(blocks_done), 128'(m_blocks));
    check({tag, "_pushes"}, 128'(push_cnt), 128'(m_blocks));
    check({tag, "_starts"}, 128'(start_cnt), 128'(m_starts));
    check({tag, "_pops"}, 128'(pop_cnt), 128'(m_words));
    check({tag, "_keyloads"}, 128'(key_load_cnt), 128'(m_key_loads));
    check({tag, "_status"}, 128'({key_loaded, err_opcode, err_nokey}),
          128'({m_key_loaded, m_err_op, m_err_nokey}));
  endtask

  // ingress FIFO driver
  initial begin
    logic [127:0] tmp;
    bus.ingress_fifo_vld = 1'b0;
    bus.ingress_fifo_dout = '0;
    forever begin
      @(posedge clk);
      #1;
      if (in_accepted && in_q.size() > 0) tmp = in_q.pop_front();
      in_accepted = 1'b0;
      if (in_q.size() > 0 && $urandom_range(0, 99) >= in_gap_pct) begin
        bus.ingress_fifo_vld = 1'b1;
        bus.ingress_fifo_dout = in_q[0];
      end else begin
        bus.ingress_fifo_vld = 1'b0;
      end
    end
  end

  // egress FIFO ready driver
  initial begin
    int held;
    held = 0;
    bus.egress_fifo_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.egress_fifo_vld) held++;
      else held = 0;
      if (eg_mode == 1) bus.egress_fifo_rdy = (held > 10);
      else bus.egress_fifo_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // round engine model
  initial begin
    logic [127:0] d, k;
    bit m;
    int lat;
    bus.core_busy = 1'b0;
    bus.core_done = 1'b0;
    bus.core_dout = '0;
    forever begin
      @(negedge clk);
      if (rst && bus.core_start) begin
        d = bus.core_din;
        m = bus.core_mode;
        k = eng_key;
        lat = $urandom_range(0, 5);
        @(posedge clk);
        #1;
        bus.core_busy = 1'b1;
        repeat (lat) begin
          @(posedge clk);
          #1;
        end
        while (eng_hold) begin
          @(posedge clk);
          #1;
        end
        bus.core_done = 1'b1;
        bus.core_dout = engine_fn(k, d, m);
        @(posedge clk);
        #1;
        bus.core_done = 1'b0;
        bus.core_busy = 1'b0;
      end
    end
  end

  // monitor + egress scoreboard
  initial begin
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.ingress_fifo_vld && bus.ingress_fifo_rdy) begin
          in_accepted = 1'b1;
          pop_cnt++;
        end
        if (bus.core_start) start_cnt++;
        if (bus.core_key_load) begin
          key_load_cnt++;
          eng_key = bus.core_key;
        end
        if (eg_prev_stall) begin
          check("egress_vld_hold", 128'(bus.egress_fifo_vld), 128'(1));
          if (bus.egress_fifo_vld) check("egress_din_hold", bus.egress_fifo_din, eg_prev_din);
        end
        if (bus.egress_fifo_vld && bus.egress_fifo_rdy) begin
          push_cnt++;
          check("push_expected", 128'(exp_q.size() != 0), 128'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("push_data", bus.egress_fifo_din, e);
          end
        end
        eg_prev_stall = bus.egress_fifo_vld && !bus.egress_fifo_rdy;
        eg_prev_din = bus.egress_fifo_din;
      end else begin
        eg_prev_stall = 1'b0;
      end
    end
  end

  // directed steps
  initial begin
    int s0, p0, c, r;
    logic [7:0] op;
    #1;
    check_reset_outputs("power_on");
    do_reset();

    // key load
    send_cmd(8'h01, 0, K0, 1'b1);
    wait_idle(500);
    check("kl_count", 128'(key_load_cnt), 128'(1));
    check("kl_key", bus.core_key, K0);
    check("kl_loaded", 128'(key_loaded), 128'(1));
    check("kl_blocks", 128'(blocks_done), 128'(0));

    // single encrypt with the reference vector
    send_cmd(8'h02, 1, P0, 1'b1);
    wait_idle(500);
    check("enc_result", bus.egress_fifo_din, C0);
    check("enc_mode", 128'(bus.core_mode), 128'(0));
    check("enc_blocks", 128'(blocks_done), 128'(1));

    // decrypt with egress backpressure
    eg_mode = 1;
    s0 = start_cnt;
    p0 = push_cnt;
    send_cmd(8'h03, 3, '0, 1'b0);
    wait_idle(1000);
    eg_mode = 0;
    check("dec_starts", 128'(start_cnt - s0), 128'(3));
    check("dec_pushes", 128'(push_cnt - p0), 128'(3));
    check("dec_mode", 128'(bus.core_mode), 128'(1));
    check_model("dec");

    // crypt with no key: payload flushed
    do_reset();
    send_cmd(8'h02, 2, '0, 1'b0);
    wait_idle(500);
    check("nokey_flag", 128'(err_nokey), 128'(1));
    check("nokey_pops", 128'(pop_cnt), 128'(3));
    check("nokey_starts", 128'(start_cnt), 128'(0));
    check("nokey_pushes", 128'(push_cnt), 128'(0));

    // unknown opcode then a normal key load
    do_reset();
    send_cmd(8'h7F, 0, '0, 1'b0);
    send_cmd(8'h01, 0, K0, 1'b1);
    wait_idle(500);
    check("badop_flag", 128'(err_opcode), 128'(1));
    check("badop_pops", 128'(pop_cnt), 128'(3));
    check("badop_key", bus.core_key, K0);
    check_model("badop");

    // randomized command stream
    do_reset();
    in_gap_pct = 30;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) send_cmd(8'h01, 0, '0, 1'b0);
      else if (r < 9) send_cmd(($urandom_range(0, 1) != 0) ? 8'h03 : 8'h02, $urandom_range(0, 4), '0, 1'b0);
      else begin
        op = 8'($urandom_range(4, 255));
        send_cmd(op, 0, '0, 1'b0);
      end
    end
    wait_idle(20000);
    check_model("rand");
    in_gap_pct = 0;

    // reset while a block is in the engine
    do_reset();
    send_cmd(8'h01, 0, '0, 1'b0);
    wait_idle(500);
    eng_hold = 1'b1;
    send_cmd(8'h02, 5, '0, 1'b0);
    c = 0;
    while (dbg_state != DBG_WAIT && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("midreset_reach_wait", 128'(dbg_state), 128'(DBG_WAIT));
    do_reset();
    eng_hold = 1'b0;
    repeat (20) @(negedge clk);
    check("midreset_pushes", 128'(push_cnt), 128'(0));
    check("midreset_blocks", 128'(blocks_done), 128'(0));
    check("midreset_vld", 128'(bus.egress_fifo_vld), 128'(0));
    check("midreset_state", 128'(dbg_state), 128'(DBG_IDLE));
    check("midreset_keyloaded", 128'(key_loaded), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end
endmodule
